// File: rtl/sprite_writer.sv
// sprite_writer: streams RGB pixels into a rectangular region of the sprite colour memories.
// Latency: one cycle from an accepted pixel to its SRAM write; done follows the final write by one cycle.
// Backpressure: in_ready is high only in WRITE (and only during vblank when gating is enabled).
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   start, x0, y0, w, h      region request, sampled in IDLE
//   vblank                   vertical blanking from the VGA controller
//   in_valid/in_ready/in_rgb pixel stream (valid/ready)
//   mem_addr/mem_wren/mem_*  registered SRAM write port
//   busy, done, err          status: in WRITE, region finished pulse, request rejected pulse
//
// Optional feature macro: SPRITE_WRITER_VBLANK_GATE_EN
//   defined   -> pixels are accepted only while vblank is high
//   undefined -> vblank is ignored (loading before scan-out is enabled)
module sprite_writer #(
    parameter int WIDTH  = 224,
    parameter int HEIGHT = 180,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [9:0]        x0,
    input  logic [8:0]        y0,
    input  logic [9:0]        w,
    input  logic [8:0]        h,
    input  logic              vblank,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_r,
    output logic [DATA_W-1:0] mem_g,
    output logic [DATA_W-1:0] mem_b,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [9:0]        col_q, col_d;
    logic [8:0]        row_q, row_d;
    logic [9:0]        w_q, w_d;
    logic [8:0]        h_q, h_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Region bounds in 11 bits so x0+w / y0+h cannot wrap.
    logic [10:0] x_end, y_end;
    logic        region_ok, accept, xfer, last_col, last_row;

    assign x_end     = {1'b0, x0} + {1'b0, w};
    assign y_end     = {2'b0, y0} + {2'b0, h};
    assign region_ok = (w != 10'd0) && (h != 9'd0) &&
                       (x_end <= 11'(WIDTH)) && (y_end <= 11'(HEIGHT));
    assign accept    = (state_q == IDLE) && start && region_ok;
    assign xfer      = in_valid && in_ready;
    assign last_col  = (col_q == w_q - 10'd1);
    assign last_row  = (row_q == h_q - 9'd1);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WRITE;
            WRITE:   if (xfer && last_col && last_row) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
`ifdef SPRITE_WRITER_VBLANK_GATE_EN
    always_comb begin
        in_ready = (state_q == WRITE) && vblank;
        busy     = (state_q == WRITE);
    end
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    always_comb begin
        in_ready = (state_q == WRITE);
        busy     = (state_q == WRITE);
    end
`endif

    // Datapath next-state: position tracking and the registered write port.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        w_d        = w_q;
        h_d        = h_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        wren_d     = 1'b0;
        // done trails the DONE state by one cycle so it lands after the final write's wren cycle.
        done_d     = (state_q == DONE);
        err_d      = (state_q == IDLE) && start && !region_ok;

        if (accept) begin
            col_d      = 10'd0;
            row_d      = 9'd0;
            w_d        = w;
            h_d        = h;
            row_base_d = ADDR_W'(y0) * ADDR_W'(WIDTH) + ADDR_W'(x0);
        end

        if (xfer) begin
            wren_d = 1'b1;
            addr_d = row_base_q + ADDR_W'(col_q);
            r_d    = in_r;
            g_d    = in_g;
            b_d    = in_b;
            if (last_col) begin
                col_d      = 10'd0;
                row_d      = row_q + 9'd1;
                row_base_d = row_base_q + ADDR_W'(WIDTH);
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_q      <= '0;
            row_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            w_q        <= w_d;
            h_q        <= h_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_wren = wren_q;
    assign mem_r    = r_q;
    assign mem_g    = g_q;
    assign mem_b    = b_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sprite_writer.sv
// Directed bench for sprite_writer: reset state, sub-region addressing, rejected requests,
// right/bottom edge boundary, blanking stall (gated build), mid-region reset and full-sprite load.
module tb_sprite_writer;

`ifdef SPRITE_WRITER_VBLANK_GATE_EN
    localparam logic VB = 1'b1;
`else
    localparam logic VB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  w;
    logic [8:0]  h;
    logic        vblank;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r, in_g, in_b;
    logic [15:0] mem_addr;
    logic        mem_wren;
    logic [7:0]  mem_r, mem_g, mem_b;
    logic        busy, done, err;

    always #5 CLK = ~CLK;

    sprite_writer dut (
        .CLK(CLK), .RST(RST), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .vblank(vblank), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .mem_addr(mem_addr), .mem_wren(mem_wren),
        .mem_r(mem_r), .mem_g(mem_g), .mem_b(mem_b),
        .busy(busy), .done(done), .err(err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_done, n_err, done_cyc;
    logic busy_at_done;
    logic [15:0] wa[$];
    logic [7:0]  wr[$], wg[$], wb[$];
    int          wc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one edge, then sample outputs 1 time unit later and log writes/pulses.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (mem_wren === 1'b1) begin
            wa.push_back(mem_addr);
            wr.push_back(mem_r);
            wg.push_back(mem_g);
            wb.push_back(mem_b);
            wc.push_back(cyc);
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (err === 1'b1) n_err++;
    endtask

    task automatic clear();
        wa.delete(); wr.delete(); wg.delete(); wb.delete(); wc.delete();
        n_done = 0; n_err = 0; done_cyc = -1; busy_at_done = 1'bx;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_mem_wren"}, 32'(mem_wren), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_r"},    32'(mem_r),    0);
        chk({tag, "_mem_g"},    32'(mem_g),    0);
        chk({tag, "_mem_b"},    32'(mem_b),    0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_done"},     32'(done),     0);
        chk({tag, "_err"},      32'(err),      0);
    endtask

    task automatic request(input int ax, input int ay, input int aw, input int ah);
        x0 = 10'(ax); y0 = 9'(ay); w = 10'(aw); h = 9'(ah);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for done, then check it came one cycle after the last write with busy low.
    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        tick(); tick();
        chk({tag, "_done_count"}, 32'(n_done), 1);
        if (wc.size() > 0)
            chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(wc[wc.size()-1] + 1));
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
    endtask

    int exp_sub[6] = '{1130, 1131, 1132, 1354, 1355, 1356};
    int rej_x[3]   = '{220, 0, 0};
    int rej_y[3]   = '{0, 0, 179};
    int rej_w[3]   = '{5, 0, 4};
    int rej_h[3]   = '{1, 1, 2};

    initial begin
        RST = 1'b1; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0;
        vblank = VB; in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0;
        clear();
        tick(); tick();
        chk_reset_outs("reset");
        RST = 1'b0;
        tick();

        // Sub-region 10,5 size 3x2; in the ungated build vblank is held low throughout.
        clear();
        request(10, 5, 3, 2);
        chk("sub_busy", 32'(busy), 1);
        chk("sub_in_ready", 32'(in_ready), 1);
        chk("sub_err", 32'(err), 0);
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_r = 8'(i); in_g = 8'(i); in_b = 8'(i);
            tick();
            if (i == 1) chk("sub_first_wren", 32'(mem_wren), 1);
        end
        in_valid = 1'b0;
        wait_done(20, "sub");
        chk("sub_nwr", 32'(wa.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wa.size()) begin
                chk($sformatf("sub_addr%0d", i), 32'(wa[i]), 32'(exp_sub[i]));
                chk($sformatf("sub_r%0d", i), 32'(wr[i]), 32'(i + 1));
                chk($sformatf("sub_g%0d", i), 32'(wg[i]), 32'(i + 1));
                chk($sformatf("sub_b%0d", i), 32'(wb[i]), 32'(i + 1));
            end
        end
        chk("sub_no_err", 32'(n_err), 0);

        // Rejected requests: stay idle, one err pulse, no writes even with in_valid high.
        for (int t = 0; t < 3; t++) begin
            clear();
            in_valid = 1'b1;
            request(rej_x[t], rej_y[t], rej_w[t], rej_h[t]);
            chk($sformatf("rej%0d_err", t), 32'(err), 1);
            chk($sformatf("rej%0d_busy", t), 32'(busy), 0);
            tick();
            chk($sformatf("rej%0d_err_pulse", t), 32'(err), 0);
            tick(); tick();
            chk($sformatf("rej%0d_nwr", t), 32'(wa.size()), 0);
            chk($sformatf("rej%0d_nerr", t), 32'(n_err), 1);
            in_valid = 1'b0;
        end

        // Region touching the right and bottom edges exactly is legal.
        clear();
        request(220, 179, 4, 1);
        chk("edge_busy", 32'(busy), 1);
        in_valid = 1'b1;
        tick(); tick(); tick(); tick();
        in_valid = 1'b0;
        wait_done(10, "edge");
        chk("edge_nwr", 32'(wa.size()), 4);
        if (wa.size() == 4) begin
            chk("edge_first_addr", 32'(wa[0]), 40316);
            chk("edge_last_addr", 32'(wa[3]), 40319);
        end

`ifdef SPRITE_WRITER_VBLANK_GATE_EN
        // Blanking stall after pixel 3 of a 4x1 load.
        clear();
        vblank = 1'b1;
        request(0, 0, 4, 1);
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_r = 8'(i); in_g = 8'(i); in_b = 8'(i);
            tick();
        end
        vblank = 1'b0;
        in_r = 8'd4; in_g = 8'd4; in_b = 8'd4;
        #1;
        chk("stall_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_wren%0d", i), 32'(mem_wren), 0);
        end
        chk("stall_nwr", 32'(wa.size()), 3);
        vblank = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(10, "stall");
        chk("stall_total", 32'(wa.size()), 4);
        if (wa.size() == 4) begin
            chk("stall_addr4", 32'(wa[3]), 3);
            chk("stall_data4", 32'(wr[3]), 4);
        end
`endif

        // Reset after 100 pixels of a full-sprite load, then restart at a new origin.
        clear();
        vblank = VB;
        request(0, 0, 224, 180);
        in_valid = 1'b1; in_r = 8'h5A; in_g = 8'hA5; in_b = 8'h3C;
        for (int i = 0; i < 100; i++) tick();
        chk("rst_nwr_before", 32'(wa.size()), 100);
        if (wa.size() == 100) chk("rst_last_addr", 32'(wa[99]), 99);
        RST = 1'b1;
        #1;
        chk_reset_outs("midrst");
        tick(); tick();
        in_valid = 1'b0;
        RST = 1'b0;
        tick(); tick();
        chk("rst_nwr_after", 32'(wa.size()), 100);
        chk("rst_no_done", 32'(n_done), 0);
        request(7, 2, 2, 1);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        wait_done(10, "restart");
        chk("restart_nwr", 32'(wa.size()), 102);
        if (wa.size() == 102) begin
            chk("restart_addr0", 32'(wa[100]), 455);
            chk("restart_addr1", 32'(wa[101]), 456);
        end

        // Full sprite at one pixel per cycle.
        clear();
        request(0, 0, 224, 180);
        in_valid = 1'b1; in_r = 8'h11; in_g = 8'h22; in_b = 8'h33;
        wait_done(41000, "full");
        in_valid = 1'b0;
        chk("full_nwr", 32'(wa.size()), 40320);
        begin
            int bad_addr = 0;
            int bad_cyc  = 0;
            for (int i = 0; i < wa.size(); i++) begin
                if (wa[i] !== 16'(i)) bad_addr++;
                if (wc[i] != wc[0] + i) bad_cyc++;
            end
            chk("full_addr_seq", 32'(bad_addr), 0);
            chk("full_back_to_back", 32'(bad_cyc), 0);
        end
        if (wa.size() > 0) chk("full_data_g", 32'(wg[0]), 32'h22);
        tick(); tick();
        chk("full_single_done", 32'(n_done), 1);
        chk("full_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
